branch_input_sequencer: RTL

BRANCH_INPUT_SEQUENCER -- requirements
Module: branch_input_sequencer

---
 rtl/siso_pkg.sv | 17 +
 rtl/branch_input_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the SISO branch-stage blocks.
//   seq_state_e : input sequencer FSM encoding (IDLE / LOAD / DRAIN)
//   addr_width  : trellis address width for a given branch size
package siso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // $clog2 of the branch size, floored at 1 so a one-item branch still has an address bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/branch_input_sequencer.sv
// Branch input sequencer: accepts one frame of {parity, systematic} LLR pairs
// over AXI-Stream after i_start, and presents each accepted beat one cycle
// later, tagged with its trellis address, to the branch metric stage.
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   i_start                   pulse arming a frame load (ignored unless idle)
//   s_axis_tdata/tvalid/tlast slave stream; tdata = {parity, systematic}
//   s_axis_tready             high while loading or draining
//   o_sys_item, o_parity_item registered LLR items
//   o_addr                    trellis index of the presented item
//   o_valid                   qualifies o_sys_item/o_parity_item/o_addr
//   o_busy                    frame in progress (LOAD or DRAIN)
//   o_frame_done              pulse with the last item of a full-length frame
//   o_frame_err               pulse with the item that ended a short or long frame
module branch_input_sequencer
  import siso_pkg::*;
#(
  parameter  int unsigned DWIDTH      = 16,
  parameter  int unsigned BRANCH_SIZE = 3072,
  localparam int unsigned AW          = addr_width(BRANCH_SIZE)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     i_start,
  input  logic [2*DWIDTH-1:0]      s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic signed [DWIDTH-1:0] o_sys_item,
  output logic signed [DWIDTH-1:0] o_parity_item,
  output logic [AW-1:0]            o_addr,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_frame_err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(BRANCH_SIZE - 1);

  seq_state_e               state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic signed [DWIDTH-1:0] sys_q, sys_d;
  logic signed [DWIDTH-1:0] par_q, par_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     accept;

  assign s_axis_tready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sys_d   = sys_q;
    par_d   = par_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          valid_d = 1'b1;
          sys_d   = s_axis_tdata[DWIDTH-1:0];
          par_d   = s_axis_tdata[2*DWIDTH-1:DWIDTH];
          addr_d  = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            // Frame full: tlast here is a clean end, otherwise the tail must be drained.
            done_d  = s_axis_tlast;
            err_d   = !s_axis_tlast;
            state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
          end else if (s_axis_tlast) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sys_q   <= '0;
      par_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_sys_item    = sys_q;
  assign o_parity_item = par_q;
  assign o_addr        = addr_q;
  assign o_valid       = valid_q;
  assign o_frame_done  = done_q;
  assign o_frame_err   = err_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule
